// File: rtl/cam_lookup_ctrl.sv
`default_nettype none
// ============================================================================
// cam_lookup_ctrl : lookup/insert controller for the CAM; CAM_LOOKUP_EVICT_EN
// enables round-robin eviction on full-miss.  Rev 1.0
// ============================================================================
module cam_lookup_ctrl #(
  parameter int DEPTH      = 32,
  parameter int DATA_W     = 32,
  parameter int IDX_W      = 5,
  parameter int SEARCH_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [DATA_W-1:0] req_key_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [IDX_W-1:0]  rsp_index_o,
  output logic              rsp_hit_o,
  output logic              rsp_full_o,
  output logic              cam_write_enable_o,
  output logic [IDX_W-1:0]  cam_write_index_o,
  output logic [DATA_W-1:0] cam_write_data_o,
  output logic              cam_search_enable_o,
  output logic [DATA_W-1:0] cam_search_data_o,
  input  logic              cam_search_valid_i,
  input  logic [IDX_W-1:0]  cam_search_index_i
);

  localparam int               CNT_W    = IDX_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [2:0]       LAT_INIT = 3'(SEARCH_LAT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_WRITE  = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [DATA_W-1:0]  key_q, key_d;
  logic [2:0]         wait_q, wait_d;
  logic [CNT_W-1:0]   alloc_cnt_q, alloc_cnt_d;
  logic               ready_q, ready_d;
  logic [IDX_W-1:0]   rsp_index_q, rsp_index_d;
  logic               rsp_hit_q, rsp_hit_d;
  logic               rsp_full_q, rsp_full_d;
  logic               full;
  logic [IDX_W-1:0]   wr_index;

`ifdef CAM_LOOKUP_EVICT_EN
  localparam logic [IDX_W-1:0] LAST_ROW = IDX_W'(DEPTH - 1);
  logic [IDX_W-1:0]   victim_ptr_q, victim_ptr_d;
  logic               evict_q, evict_d;

  assign wr_index = evict_q ? victim_ptr_q : alloc_cnt_q[IDX_W-1:0];
`else
  assign wr_index = alloc_cnt_q[IDX_W-1:0];
`endif

  assign full = (alloc_cnt_q == FULL_CNT);

  always_comb begin
    state_d     = state_q;
    key_d       = key_q;
    wait_d      = wait_q;
    alloc_cnt_d = alloc_cnt_q;
    rsp_index_d = rsp_index_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_full_d  = rsp_full_q;
`ifdef CAM_LOOKUP_EVICT_EN
    victim_ptr_d = victim_ptr_q;
    evict_d      = evict_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_valid_i && ready_q) begin
          key_d   = req_key_i;
          wait_d  = LAT_INIT;
          state_d = S_SEARCH;
        end
      end
      S_SEARCH: begin
        // match inputs are only trusted once the CAM latency has elapsed
        if (wait_q != 3'd0) begin
          wait_d = wait_q - 3'd1;
        end else if (cam_search_valid_i) begin
          rsp_hit_d   = 1'b1;
          rsp_full_d  = 1'b0;
          rsp_index_d = cam_search_index_i;
          state_d     = S_RESP;
        end else if (!full) begin
`ifdef CAM_LOOKUP_EVICT_EN
          evict_d = 1'b0;
`endif
          state_d = S_WRITE;
        end else begin
`ifdef CAM_LOOKUP_EVICT_EN
          evict_d = 1'b1;
          state_d = S_WRITE;
`else
          rsp_hit_d   = 1'b0;
          rsp_full_d  = 1'b1;
          rsp_index_d = '0;
          state_d     = S_RESP;
`endif
        end
      end
      S_WRITE: begin
        rsp_index_d = wr_index;
        rsp_hit_d   = 1'b0;
        rsp_full_d  = 1'b0;
`ifdef CAM_LOOKUP_EVICT_EN
        if (evict_q) begin
          rsp_full_d   = 1'b1;
          victim_ptr_d = (victim_ptr_q == LAST_ROW) ? '0 : victim_ptr_q + IDX_W'(1);
        end else if (!full) begin
          alloc_cnt_d = alloc_cnt_q + CNT_W'(1);
        end
`else
        if (!full) begin
          alloc_cnt_d = alloc_cnt_q + CNT_W'(1);
        end
`endif
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready_i) begin
          rsp_index_d = '0;
          rsp_hit_d   = 1'b0;
          rsp_full_d  = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // registered so that ready stays low during reset and rises on the first edge after it
    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      key_q       <= '0;
      wait_q      <= '0;
      alloc_cnt_q <= '0;
      ready_q     <= 1'b0;
      rsp_index_q <= '0;
      rsp_hit_q   <= 1'b0;
      rsp_full_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      wait_q      <= wait_d;
      alloc_cnt_q <= alloc_cnt_d;
      ready_q     <= ready_d;
      rsp_index_q <= rsp_index_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_full_q  <= rsp_full_d;
    end
  end

`ifdef CAM_LOOKUP_EVICT_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      victim_ptr_q <= '0;
      evict_q      <= 1'b0;
    end else begin
      victim_ptr_q <= victim_ptr_d;
      evict_q      <= evict_d;
    end
  end
`endif

  assign req_ready_o         = ready_q;
  assign rsp_valid_o         = (state_q == S_RESP);
  assign rsp_index_o         = rsp_index_q;
  assign rsp_hit_o           = rsp_hit_q;
  assign rsp_full_o          = rsp_full_q;
  assign cam_search_enable_o = (state_q == S_SEARCH);
  assign cam_search_data_o   = (state_q == S_SEARCH) ? key_q : '0;
  assign cam_write_enable_o  = (state_q == S_WRITE);
  assign cam_write_index_o   = (state_q == S_WRITE) ? wr_index : '0;
  assign cam_write_data_o    = (state_q == S_WRITE) ? key_q : '0;

endmodule
`default_nettype wire

// File: doc/cam_lookup_ctrl.md
Name: cam_lookup_ctrl

Overview:
- Initiator-side controller for the 32-entry CAM.
- Accepts key requests from upstream, drives the CAM search port and waits for the match result.
- On hit, returns the matching index. On miss, allocates the next free row, writes the key through the CAM write port and returns the new index.
- Sits between the packet/flow logic and the CAM. It owns all CAM write and search traffic.

Parameters:
- DEPTH, 32: number of CAM rows.
- DATA_W, 32: key width.
- IDX_W, 5: index width. Must equal clog2(DEPTH).
- SEARCH_LAT, 1: cycles from first search_enable cycle to a valid search_valid/search_index. Legal range 0..7.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  upstream key request valid.
- req_ready_o  out  1  controller can accept a request.
- req_key_i  in  DATA_W  key to look up or insert.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  downstream accepts response.
- rsp_index_o  out  IDX_W  hit index or newly allocated index.
- rsp_hit_o  out  1  key already present.
- rsp_full_o  out  1  miss with table full.
- cam_write_enable_o  out  1  CAM write strobe.
- cam_write_index_o  out  IDX_W  CAM write row.
- cam_write_data_o  out  DATA_W  CAM write data.
- cam_search_enable_o  out  1  CAM search strobe.
- cam_search_data_o  out  DATA_W  CAM search key.
- cam_search_valid_i  in  1  CAM reports a match.
- cam_search_index_i  in  IDX_W  lowest matching row.

Behaviour:
- Reset (rst_i=0, async):
  - State IDLE, alloc_cnt=0, key register=0.
  - All outputs 0, except req_ready_o=0 while in reset.
  - Reset mid-operation abandons the transaction. No partial write completes after reset asserts.
- FSM states: IDLE, SEARCH, WRITE, RESP.
- IDLE:
  - req_ready_o=1.
  - On req_valid_i & req_ready_o (accept cycle c): latch req_key_i and go to SEARCH.
- SEARCH:
  - cam_search_enable_o=1 and cam_search_data_o=latched key, held for SEARCH_LAT+1 cycles (c+1 .. c+1+SEARCH_LAT).
  - A wait counter counts down. Match inputs are sampled only in the final cycle, c+1+SEARCH_LAT.
- Decision, on the sample edge:
  - Hit: rsp_hit_o=1, rsp_index_o=cam_search_index_i. Go to RESP.
  - Miss with alloc_cnt<DEPTH: go to WRITE.
  - Miss with alloc_cnt==DEPTH: rsp_full_o=1, rsp_hit_o=0, rsp_index_o=0. Go to RESP. No write is issued.
- WRITE, exactly one cycle:
  - cam_write_enable_o=1, cam_write_index_o=alloc_cnt, cam_write_data_o=key.
  - rsp_index_o<=alloc_cnt, alloc_cnt<=alloc_cnt+1. Go to RESP.
- RESP:
  - rsp_valid_o=1. rsp_index_o, rsp_hit_o and rsp_full_o are held stable until rsp_ready_i=1.
  - On handshake: clear response outputs and go to IDLE.
  - req_ready_o=0 in every state except IDLE. There is no request overlap.
- Latency, with L=SEARCH_LAT:
  - Hit: rsp_valid_o at c+2+L.
  - Miss-insert: rsp_valid_o at c+3+L.
  - Full-miss: rsp_valid_o at c+2+L.
  - For L=1: hit c+3, insert c+4.
- alloc_cnt:
  - IDX_W+1 bits, saturates at DEPTH and never wraps.
  - full = (alloc_cnt==DEPTH).
- All CAM-side outputs are 0 whenever their strobe is 0.
- cam_search_enable_o and cam_write_enable_o are never high in the same cycle.

Optional Feature:
- Macro: CAM_LOOKUP_EVICT_EN.
- Defined:
  - A full-miss performs a WRITE at victim_ptr instead of skipping the write.
  - victim_ptr is IDX_W bits, reset 0, increments after each eviction and wraps DEPTH-1 -> 0.
  - Response: rsp_full_o=1, rsp_hit_o=0, rsp_index_o=victim row, rsp_valid_o at c+3+L.
- Undefined:
  - No victim_ptr logic is present.
  - A full-miss returns rsp_full_o=1, rsp_index_o=0, with no CAM write.

Test Plan:
- After reset, req key 0xDEADBEEF, CAM empty -> one write at index 0 with data 0xDEADBEEF; rsp hit=0 full=0 idx=0 at c+4.
- Repeat 0xDEADBEEF with CAM returning valid=1 idx=0 -> no write; rsp hit=1 idx=0 at c+3.
- Insert 32 distinct keys 0x100..0x11F -> writes at indices 0..31 in order, all full=0. A 33rd key 0x200 -> full=1, hit=0, idx=0, no write (macro off).
- Hold rsp_ready_i=0 for 5 cycles on a hit response -> rsp_* stable, req_ready_o=0, no CAM strobes. Release -> IDLE and req_ready_o=1 next cycle.
- Assert rst_i=0 during SEARCH wait -> all outputs 0 immediately. After release, a new key inserts at index 0.
- CAM_LOOKUP_EVICT_EN defined, table full: two new keys -> writes at indices 0 then 1, each with full=1.
